// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default Q8.8 geometry, clamp limits, divider FSM
// states and the saturation helper also used by the multiplier datapath.
package fixed_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned FRAC_DEF  = 8;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] q;
  } sat_t;

  // Sign-magnitude to two's complement with clamping; q holds the result in its low width bits.
  function automatic sat_t saturate(input logic neg, input logic [63:0] mag, input int unsigned width);
    sat_t        r;
    logic [63:0] lim;
    lim   = 64'd1 << (width - 1);
    r.sat = 1'b0;
    if (!neg && (mag > (lim - 64'd1))) begin
      r.sat = 1'b1;
      r.q   = lim - 64'd1;
    end else if (neg && (mag > lim)) begin
      r.sat = 1'b1;
      r.q   = lim;
    end else if (neg) begin
      r.q = ~mag + 64'd1;
    end else begin
      r.q = mag;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_divider.sv
// Signed saturating fixed-point divider: one-bit-per-cycle restoring division of
// |a|<<FRAC_BITS by |b| with valid/ready handshakes on both sides.
module fixed_divider
  import fixed_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned FRAC_BITS = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             div_zero,
  output logic             sat
);

  localparam int unsigned N  = WIDTH + FRAC_BITS;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_q;
  logic             r_div_zero;
  logic             r_sat;
  logic             r_neg;
  logic [WIDTH-1:0] r_rem;
  logic [N-1:0]     r_quo;
  logic [RW-1:0]    r_div;
  logic [CW-1:0]    r_cnt;

  logic [RW-1:0]    w_a_ext;
  logic [RW-1:0]    w_b_ext;
  logic [RW-1:0]    w_abs_a;
  logic [RW-1:0]    w_abs_b;
  logic [N-1:0]     w_dividend;
  logic [RW-1:0]    w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_diff;
  logic [N-1:0]     w_quo_nx;
  sat_t             w_res;
  sat_t             w_dz;

  assign w_a_ext    = {a[WIDTH-1], a};
  assign w_b_ext    = {b[WIDTH-1], b};
  assign w_abs_a    = a[WIDTH-1] ? -w_a_ext : w_a_ext;
  assign w_abs_b    = b[WIDTH-1] ? -w_b_ext : w_b_ext;
  assign w_dividend = N'({w_abs_a, {FRAC_BITS{1'b0}}});

  // r_quo starts as the dividend and fills with quotient bits from the bottom as it shifts out.
  assign w_rem_sh   = {r_rem, r_quo[N-1]};
  assign w_ge       = (w_rem_sh >= r_div);
  assign w_rem_diff = WIDTH'(w_rem_sh - r_div);
  assign w_quo_nx   = {r_quo[N-2:0], w_ge};

  assign w_res = saturate(r_neg, 64'(w_quo_nx), WIDTH);
  assign w_dz  = saturate(a[WIDTH-1], '1, WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_div_zero  <= 1'b0;
      r_sat       <= 1'b0;
      r_neg       <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (b == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_div_zero  <= 1'b1;
              r_sat       <= 1'b1;
              r_q         <= WIDTH'(w_dz.q);
            end else begin
              r_state    <= CALC;
              r_div_zero <= 1'b0;
              r_neg      <= a[WIDTH-1] ^ b[WIDTH-1];
              r_rem      <= '0;
              r_quo      <= w_dividend;
              r_div      <= w_abs_b;
              r_cnt      <= '0;
            end
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_q         <= WIDTH'(w_res.q);
            r_sat       <= w_res.sat;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign div_zero  = r_div_zero;
  assign sat       = r_sat;

endmodule

// File: tb/tb_fixed_divider.sv
// Directed bench for fixed_divider (Q8.8): arithmetic vectors, divide-by-zero,
// back-pressure, ignored inputs while busy and mid-calculation reset.
module tb_fixed_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        div_zero;
  logic        sat;

  int total = 0;
  int bad   = 0;

  localparam int NV = 15;
  logic [15:0] va   [NV] = '{16'h0300, 16'hFD00, 16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 16'h8000,
                             16'h0100, 16'hFF00, 16'h0000, 16'hFFFF, 16'hC000, 16'h4000, 16'hC000, 16'h0001};
  logic [15:0] vb   [NV] = '{16'h0200, 16'h0200, 16'h0300, 16'h0300, 16'h0001, 16'hFF00, 16'h0100,
                             16'h0000, 16'h0000, 16'hFD00, 16'h0100, 16'h0080, 16'h0080, 16'h007F, 16'h7FFF};
  logic [15:0] vq   [NV] = '{16'h0180, 16'hFE80, 16'h0055, 16'hFFAB, 16'h7FFF, 16'h7FFF, 16'h8000,
                             16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000};
  logic        vsat [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        vdz  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          vlat [NV] = '{25, 25, 25, 25, 25, 25, 25, 1, 1, 25, 25, 25, 25, 25, 25};

  always #5 clk = ~clk;

  fixed_divider #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .div_zero  (div_zero),
    .sat       (sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency counts rising edges from the handshake cycle to the first cycle with out_valid.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        output logic [15:0] oq, output logic odz, output logic osat, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    step();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    oq   = q;
    odz  = div_zero;
    osat = sat;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    step(); step();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (q !== 16'h0000)     begin bad++; $display("FAIL reset q: got %h want 0000", q); end
    total++; if (div_zero !== 1'b0)  begin bad++; $display("FAIL reset div_zero: got %b want 0", div_zero); end
    total++; if (sat !== 1'b0)       begin bad++; $display("FAIL reset sat: got %b want 0", sat); end
    rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL post-reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [15:0] rq;
    logic        rdz, rsat;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      run_op(va[i], vb[i], rq, rdz, rsat, lat);
      total++; if (rq !== vq[i])     begin bad++; $display("FAIL vec%0d q: got %h want %h", i, rq, vq[i]); end
      total++; if (rsat !== vsat[i]) begin bad++; $display("FAIL vec%0d sat: got %b want %b", i, rsat, vsat[i]); end
      total++; if (rdz !== vdz[i])   begin bad++; $display("FAIL vec%0d div_zero: got %b want %b", i, rdz, vdz[i]); end
      total++; if (lat !== vlat[i])  begin bad++; $display("FAIL vec%0d latency: got %0d want %0d", i, lat, vlat[i]); end
      step();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL vec%0d release: got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] rq;
    logic        rdz, rsat;
    int          lat;
    out_ready = 1'b0;
    run_op(16'h0100, 16'h0300, rq, rdz, rsat, lat);
    total++; if (rq !== 16'h0055) begin bad++; $display("FAIL bp q: got %h want 0055", rq); end
    in_valid = 1'b1; a = 16'h0100; b = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if ({out_valid, in_ready, div_zero, sat, q} !== {4'b1000, 16'h0055}) begin
        bad++; $display("FAIL bp hold%0d: got ov=%b ir=%b dz=%b sat=%b q=%h want 1 0 0 0 0055",
                        i, out_valid, in_ready, div_zero, sat, q);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0300; b = 16'h0200;
    step();
    a = 16'h0100; b = 16'h0000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    total++; if (lat !== 25) begin bad++; $display("FAIL busy latency: got %0d want 25", lat); end
    total++; if (q !== 16'h0180 || div_zero !== 1'b0) begin
      bad++; $display("FAIL busy result: got q=%h dz=%b want 0180/0", q, div_zero);
    end
    step();
  endtask

  task automatic test_reset_mid_calc();
    logic [15:0] rq;
    logic        rdz, rsat;
    int          lat;
    int          seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0300; b = 16'h0200;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    #2 rst = 1'b1;
    #2;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid-rst async: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid-rst discard: got %0d out_valid cycles want 0", seen); end
    run_op(16'h0300, 16'h0200, rq, rdz, rsat, lat);
    total++; if (rq !== 16'h0180 || lat !== 25) begin
      bad++; $display("FAIL mid-rst next op: got q=%h lat=%0d want 0180/25", rq, lat);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_divider.md
FIXED_DIVIDER -- requirements
Module: fixed_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (signed Q(WIDTH-FRAC_BITS).FRAC_BITS).
REQ-002 SHALL have parameter FRAC_BITS, default 8, number of fractional bits.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operands a/b valid.
REQ-007 in_ready  output  1  divider can accept operands.
REQ-008 a  input  WIDTH  signed dividend, Q8.8.
REQ-009 b  input  WIDTH  signed divisor, Q8.8.
REQ-010 out_valid  output  1  result q valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 q  output  WIDTH  signed saturated quotient, Q8.8.
REQ-013 div_zero  output  1  b was zero for current result.
REQ-014 sat  output  1  result was clamped to Q_MAX/Q_MIN.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; input handshake = in_valid && in_ready in cycle T; a/b SHALL be captured at T.
REQ-017 On handshake with b != 0, SHALL enter CALC at T+1 and run unsigned restoring division of |a|<<FRAC_BITS (WIDTH+FRAC_BITS bits) by |b|, one quotient bit per cycle, WIDTH+FRAC_BITS (24) cycles.
REQ-018 After last CALC cycle SHALL enter DONE; out_valid SHALL first be 1 at T+25 (default params).
REQ-019 On handshake with b == 0, SHALL enter DONE at T+1 with div_zero=1, sat=1, q=0x7FFF if a>=0 else 0x8000.
REQ-020 Quotient SHALL truncate toward zero; sign = sign(a) XOR sign(b); magnitudes computed with WIDTH+1 bits so |0x8000| is exact.
REQ-021 Positive result magnitude > 0x7FFF SHALL yield q=0x7FFF, sat=1; negative magnitude > 0x8000 SHALL yield q=0x8000, sat=1; otherwise sat=0.
REQ-022 Zero-magnitude quotient SHALL yield q=0x0000 regardless of sign.
REQ-023 In DONE, q/div_zero/sat/out_valid SHALL hold stable while out_ready=0.
REQ-024 Output handshake (out_valid && out_ready) SHALL return FSM to IDLE next cycle; no input accepted in same cycle as output handshake.
REQ-025 in_valid during CALC/DONE SHALL be ignored (not captured).

Reset
REQ-026 rst SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, q=0, div_zero=0, sat=0, internal remainder/quotient registers cleared.
REQ-027 rst asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow.

Structure
REQ-028 Shared package fixed_pkg SHALL hold WIDTH/FRAC_BITS defaults, Q_MAX=0x7FFF, Q_MIN=0x8000, FSM state enum, and a pure saturate function shared with the multiplier datapath.
REQ-029 No sub-module is required; iteration counter, remainder, quotient registers live in fixed_divider.

Verification
REQ-030 a=0x0300, b=0x0200 at T -> q=0x0180, sat=0, div_zero=0, out_valid at T+25.
REQ-031 a=0xFD00, b=0x0200 -> q=0xFE80; a=0x0100, b=0x0300 -> q=0x0055; a=0xFF00, b=0x0300 -> q=0xFFAB.
REQ-032 a=0x7FFF, b=0x0001 -> q=0x7FFF, sat=1; a=0x8000, b=0xFF00 -> q=0x7FFF, sat=1; a=0x8000, b=0x0100 -> q=0x8000, sat=0.
REQ-033 a=0x0100, b=0x0000 -> q=0x7FFF, div_zero=1, out_valid at T+1; a=0xFF00, b=0 -> q=0x8000.
REQ-034 out_ready=0 for 10 cycles in DONE -> q stable, in_ready=0; raise out_ready -> in_ready=1 next cycle.
REQ-035 rst pulse at T+10 mid-CALC -> out_valid never asserts; next operation 0x0300/0x0200 returns 0x0180.
